// File: rtl/vga_rx_monitor.sv
// VGA receive-side timing monitor: locks onto hsync/vsync timing and re-emits visible pixels.
// Define VGA_RX_ERR_CNT_EN to add the saturating o_err_cnt error counter output.
`timescale 1ns / 1ps

module vga_rx_monitor #(
  parameter int unsigned H_TOTAL  = 1040,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_TOTAL  = 666,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23,
  parameter int unsigned V_ACTIVE = 600,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic       clk_50Mhz,
  input  logic       reset,
  input  logic       i_h_sync,
  input  logic       i_v_sync,
  input  logic       i_r,
  input  logic       i_g,
  input  logic       i_b,
  output logic       o_locked,
  output logic       o_pixel_valid,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_r,
  output logic       o_g,
  output logic       o_b,
  output logic       o_frame_start,
`ifdef VGA_RX_ERR_CNT_EN
  output logic       o_err,
  output logic [7:0] o_err_cnt
`else
  output logic       o_err
`endif
);

  localparam int unsigned HStart = H_SYNC + H_BP;
  localparam int unsigned HEnd   = HStart + H_ACTIVE - 1;
  localparam int unsigned VStart = V_SYNC + V_BP;
  localparam int unsigned VEnd   = VStart + V_ACTIVE - 1;
  localparam logic [10:0] HStartW = 11'(HStart);
  localparam logic [9:0]  VStartW = 10'(VStart);

  typedef enum logic [1:0] {StSearch, StSyncing, StLocked} state_e;

  state_e state_q, state_d;

  // S1 input register plus the previous S1 sync values for edge detection
  logic hs_q, vs_q, r_q, g_q, b_q;
  logic hs_prev_q, vs_prev_q;

  logic hs_act, hs_act_prev, vs_act, vs_act_prev;
  logic hs_rise, hs_fall, vs_rise;

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        h_seen_q, h_seen_d;

  logic err_line, err_pulse, err_frame, err_any;

  logic       in_h, in_v;
  logic       pix_valid_d;
  logic [10:0] x_full;
  logic [9:0]  x_d, y_d;

  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      hs_prev_q <= ~SYNC_POL;
      vs_prev_q <= ~SYNC_POL;
      r_q       <= 1'b0;
      g_q       <= 1'b0;
      b_q       <= 1'b0;
    end else begin
      hs_q      <= i_h_sync;
      vs_q      <= i_v_sync;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      r_q       <= i_r;
      g_q       <= i_g;
      b_q       <= i_b;
    end
  end

  assign hs_act      = (hs_q == SYNC_POL);
  assign hs_act_prev = (hs_prev_q == SYNC_POL);
  assign vs_act      = (vs_q == SYNC_POL);
  assign vs_act_prev = (vs_prev_q == SYNC_POL);

  assign hs_rise = hs_act & ~hs_act_prev;
  assign hs_fall = ~hs_act & hs_act_prev;
  assign vs_rise = vs_act & ~vs_act_prev;

  // hcnt_d/vcnt_d are the line/frame position of the sample currently held in S1
  always_comb begin
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    h_seen_d = h_seen_q;
    if (hs_rise) begin
      hcnt_d   = '0;
      h_seen_d = 1'b1;
    end else if (hcnt_q != 11'h7ff) begin
      hcnt_d = hcnt_q + 11'd1;
    end
    if (vs_rise) begin
      vcnt_d = '0;
    end else if (hs_rise && (vcnt_q != 10'h3ff)) begin
      vcnt_d = vcnt_q + 10'd1;
    end
  end

  always_comb begin
    err_line  = hs_rise & h_seen_q & ((32'(hcnt_q) + 32'd1) != H_TOTAL);
    err_pulse = hs_fall & h_seen_q & ((32'(hcnt_q) + 32'd1) != H_SYNC);
    err_frame = vs_rise & ((32'(vcnt_q) + 32'd1) != V_TOTAL);
    err_any   = (state_q != StSearch) & (err_line | err_pulse | err_frame);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSearch: begin
        if (vs_rise) state_d = StSyncing;
      end
      StSyncing: begin
        if (err_any)      state_d = StSearch;
        else if (vs_rise) state_d = StLocked;
      end
      StLocked: begin
        if (err_any) state_d = StSearch;
      end
      default: state_d = StSearch;
    endcase
  end

  always_comb begin
    in_h        = (32'(hcnt_d) >= HStart) && (32'(hcnt_d) <= HEnd);
    in_v        = (32'(vcnt_d) >= VStart) && (32'(vcnt_d) <= VEnd);
    pix_valid_d = (state_d == StLocked) && in_h && in_v;
    x_full      = hcnt_d - HStartW;
    x_d         = pix_valid_d ? x_full[9:0] : '0;
    y_d         = pix_valid_d ? (vcnt_d - VStartW) : '0;
  end

  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      state_q       <= StSearch;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      h_seen_q      <= 1'b0;
      o_locked      <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_r           <= 1'b0;
      o_g           <= 1'b0;
      o_b           <= 1'b0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      h_seen_q      <= h_seen_d;
      o_locked      <= (state_d == StLocked);
      o_pixel_valid <= pix_valid_d;
      o_x           <= x_d;
      o_y           <= y_d;
      o_r           <= pix_valid_d & r_q;
      o_g           <= pix_valid_d & g_q;
      o_b           <= pix_valid_d & b_q;
      // Covers the vs_rise that moves SYNCING into LOCKED as well
      o_frame_start <= vs_rise & (state_d == StLocked);
      o_err         <= err_any;
    end
  end

`ifdef VGA_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (o_err && (err_cnt_q != 8'hff)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign o_err_cnt = err_cnt_q;
`endif

endmodule
